// File: rtl/video_pattern_gen_if.sv
// Camera-style pixel stream bundle between the pattern generator and the
// image pipeline: run/pattern controls in, RGB plus raster timing out.
interface video_pattern_gen_if;
    logic        iEnable;
    logic [2:0]  iPattern;
    logic [23:0] iColor;
    logic [7:0]  oR;
    logic [7:0]  oG;
    logic [7:0]  oB;
    logic        oHSync;
    logic        oVSync;
    logic        oLineValid;
    logic        oFrameValid;
    logic [15:0] oFrameCount;
    logic        oBusy;

    modport master (
        input  iEnable, iPattern, iColor,
        output oR, oG, oB, oHSync, oVSync, oLineValid, oFrameValid, oFrameCount, oBusy
    );

    modport slave (
        output iEnable, iPattern, iColor,
        input  oR, oG, oB, oHSync, oVSync, oLineValid, oFrameValid, oFrameCount, oBusy
    );
endinterface

// File: rtl/video_pattern_gen.sv
// Programmable raster timing generator with selectable test patterns, used in
// place of the camera for bring-up and resolution/FPS measurement checks.
// Optional build macro PATTERN_GEN_BORDER_EN forces a one-pixel white frame
// around the active area on top of any pattern.
// H_ACTIVE must be at least 8 so every colour bar is at least one pixel wide.
module video_pattern_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic               iClk,
    input  logic               iRst,
    video_pattern_gen_if.master vid
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int HXW     = HW + 1;
    localparam int VXW     = VW + 1;
    localparam int BW      = H_ACTIVE / 8;

    // Window bounds are compared one bit wider so an end bound equal to the
    // total count still fits.
    localparam logic [HXW-1:0] H_ACT_X  = HXW'(H_ACTIVE);
    localparam logic [HXW-1:0] H_SYN_S  = HXW'(H_ACTIVE + H_FP);
    localparam logic [HXW-1:0] H_SYN_E  = HXW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VXW-1:0] V_ACT_X  = VXW'(V_ACTIVE);
    localparam logic [VXW-1:0] V_SYN_S  = VXW'(V_ACTIVE + V_FP);
    localparam logic [VXW-1:0] V_SYN_E  = VXW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [HW-1:0]  H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0]  V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [HW-1:0]  BAR_LAST = HW'(BW - 1);
`ifdef PATTERN_GEN_BORDER_EN
    localparam logic [HW-1:0]  H_EDGE   = HW'(H_ACTIVE - 1);
    localparam logic [VW-1:0]  V_EDGE   = VW'(V_ACTIVE - 1);
`endif
    localparam logic [23:0]    WHITE    = 24'hFFFFFF;

    typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

    state_t          state;
    state_t          stateNext;
    logic            running;
    logic [HW-1:0]   hcnt;
    logic [VW-1:0]   vcnt;
    logic [HW-1:0]   barCnt;
    logic [2:0]      barIdx;
    logic [HXW-1:0]  hx;
    logic [VXW-1:0]  vx;
    logic            lineEnd;
    logic            frameEnd;
    logic            frameStart;
    logic            lineAct;
    logic            frameAct;
    logic            hsWin;
    logic            vsWin;
    logic [2:0]      patReg;
    logic [2:0]      patCur;
    logic [23:0]     colReg;
    logic [23:0]     colCur;
    logic [15:0]     xExt;
    logic [15:0]     yExt;
    logic [15:0]     barPos;
    logic            movHit;
    logic [23:0]     pixel;
    logic            lvNext;
    logic            fvNext;
    logic            hsNext;
    logic            vsNext;

    // Bar index advance that stops at the last bar, so the remainder of
    // H_ACTIVE/8 folds into the final (black) bar.
    function automatic logic [2:0] satInc3(input logic [2:0] v);
        return (v == 3'd7) ? v : v + 3'd1;
    endfunction

    assign hx         = {1'b0, hcnt};
    assign vx         = {1'b0, vcnt};
    assign lineEnd    = (hcnt == H_LAST);
    assign frameEnd   = lineEnd && (vcnt == V_LAST);
    assign frameStart = (hcnt == '0) && (vcnt == '0);
    assign lineAct    = (hx < H_ACT_X) && (vx < V_ACT_X);
    assign frameAct   = (vx < V_ACT_X);
    assign hsWin      = (hx >= H_SYN_S) && (hx < H_SYN_E);
    assign vsWin      = (vx >= V_SYN_S) && (vx < V_SYN_E);
    assign xExt       = 16'(hcnt);
    assign yExt       = 16'(vcnt);

    // Pattern and colour apply from the very first pixel of a frame, so the
    // live inputs are used at frame start and the latched copy afterwards.
    assign patCur = frameStart ? vid.iPattern : patReg;
    assign colCur = frameStart ? vid.iColor   : colReg;

    // Moving bar position follows the completed-frame count, 4 px per frame.
    assign barPos = 16'((32'(vid.oFrameCount[7:0]) * 32'd4) % 32'(H_ACTIVE));
    assign movHit = (xExt >= barPos) && (xExt < barPos + 16'd8);

    // State register.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) state <= IDLE;
        else      state <= stateNext;
    end

    // Next-state: stopping always finishes the current frame before idling.
    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (vid.iEnable) stateNext = RUN;
            RUN:     if (!vid.iEnable) stateNext = STOP;
            STOP: begin
                if (vid.iEnable)   stateNext = RUN;
                else if (frameEnd) stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    // FSM outputs: counting and the busy flag both follow "not idle".
    always_comb begin
        running  = (state != IDLE);
        vid.oBusy = running;
    end

    // Raster counters, held at zero while idle.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (!running) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (lineEnd) begin
            hcnt <= '0;
            vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 1'b1;
        end else begin
            hcnt <= hcnt + 1'b1;
        end
    end

    // Latch pattern select and solid colour at every frame start.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            patReg <= '0;
            colReg <= '0;
        end else if (frameStart) begin
            patReg <= vid.iPattern;
            colReg <= vid.iColor;
        end
    end

    // Colour-bar tracker: a run counter of BW pixels per bar instead of a divide.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            barCnt <= '0;
            barIdx <= '0;
        end else if (!running || lineEnd) begin
            barCnt <= '0;
            barIdx <= '0;
        end else if (barCnt == BAR_LAST) begin
            barCnt <= '0;
            barIdx <= satInc3(barIdx);
        end else begin
            barCnt <= barCnt + 1'b1;
        end
    end

    // Pixel and timing decode for the current counter position.
    always_comb begin
        pixel  = '0;
        lvNext = running && lineAct;
        fvNext = running && frameAct;
        hsNext = running && hsWin;
        vsNext = running && vsWin;
        if (lvNext) begin
            case (patCur)
                3'd0:    pixel = colCur;
                3'd1:    pixel = {{8{~barIdx[1]}}, {8{~barIdx[2]}}, {8{~barIdx[0]}}};
                3'd2:    pixel = {3{xExt[7:0]}};
                3'd3:    pixel = (((xExt ^ yExt) & 16'h0010) != 16'h0) ? WHITE : 24'h0;
                3'd4:    pixel = movHit ? WHITE : 24'h0;
                default: pixel = '0;
            endcase
`ifdef PATTERN_GEN_BORDER_EN
            if ((hcnt == '0) || (hcnt == H_EDGE) || (vcnt == '0) || (vcnt == V_EDGE))
                pixel = WHITE;
`endif
        end
    end

    // Output registers; the frame counter steps as FrameValid falls.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            vid.oR          <= '0;
            vid.oG          <= '0;
            vid.oB          <= '0;
            vid.oHSync      <= ~SYNC_POL;
            vid.oVSync      <= ~SYNC_POL;
            vid.oLineValid  <= 1'b0;
            vid.oFrameValid <= 1'b0;
            vid.oFrameCount <= '0;
        end else begin
            vid.oR          <= pixel[23:16];
            vid.oG          <= pixel[15:8];
            vid.oB          <= pixel[7:0];
            vid.oHSync      <= hsNext ? SYNC_POL : ~SYNC_POL;
            vid.oVSync      <= vsNext ? SYNC_POL : ~SYNC_POL;
            vid.oLineValid  <= lvNext;
            vid.oFrameValid <= fvNext;
            if (vid.oFrameValid && !fvNext)
                vid.oFrameCount <= vid.oFrameCount + 16'd1;
        end
    end

endmodule

// File: tb/tb_video_pattern_gen.sv
// Bench for video_pattern_gen at an 8x4 active raster (14x7 total), checking
// every output each cycle against a frame-position reference model.
module tb_video_pattern_gen;

    localparam int HA  = 8;
    localparam int HFP = 2;
    localparam int HSY = 2;
    localparam int HBP = 2;
    localparam int VA  = 4;
    localparam int VFP = 1;
    localparam int VSY = 1;
    localparam int VBP = 1;
    localparam int HT  = HA + HFP + HSY + HBP;
    localparam int VT  = VA + VFP + VSY + VBP;
    localparam int FRAME = HT * VT;
    localparam bit SP  = 1'b0;

    logic iClk = 1'b0;
    logic iRst = 1'b1;

    int checks = 0;
    int errors = 0;

    // Reference model state: frame position rather than separate counters.
    bit          mBusy   = 1'b0;
    int          mPos    = 0;
    int          mFc     = 0;
    bit          mPrevFv = 1'b0;
    bit          mPrevEn = 1'b0;
    int          mPat    = 0;
    logic [23:0] mCol    = '0;

    video_pattern_gen_if vif();

    video_pattern_gen #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
        .SYNC_POL(SP)
    ) dut (
        .iClk(iClk),
        .iRst(iRst),
        .vid (vif)
    );

    always #5 iClk = ~iClk;

    function automatic logic [23:0] barColor(input int b);
        case (b)
            0: return 24'hFFFFFF;
            1: return 24'hFFFF00;
            2: return 24'h00FFFF;
            3: return 24'h00FF00;
            4: return 24'hFF00FF;
            5: return 24'hFF0000;
            6: return 24'h0000FF;
            default: return 24'h000000;
        endcase
    endfunction

    function automatic logic [23:0] refPixel(input int x, input int y, input int pat,
                                             input logic [23:0] col, input int fc);
        logic [23:0] px;
        int b;
        int k;
        px = 24'h0;
        if (x < HA && y < VA) begin
            case (pat)
                0: px = col;
                1: begin
                    b = x / (HA / 8);
                    if (b > 7) b = 7;
                    px = barColor(b);
                end
                2: px = {3{8'(x % 256)}};
                3: px = (((x / 16) % 2) != ((y / 16) % 2)) ? 24'hFFFFFF : 24'h0;
                4: begin
                    k = ((fc % 256) * 4) % HA;
                    px = (x >= k && x < k + 8) ? 24'hFFFFFF : 24'h0;
                end
                default: px = 24'h0;
            endcase
`ifdef PATTERN_GEN_BORDER_EN
            if (x == 0 || x == HA - 1 || y == 0 || y == VA - 1) px = 24'hFFFFFF;
`endif
        end
        return px;
    endfunction

    function automatic logic [63:0] obsVec();
        return 64'({vif.oR, vif.oG, vif.oB, vif.oHSync, vif.oVSync, vif.oLineValid,
                    vif.oFrameValid, vif.oFrameCount, vif.oBusy});
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: predict the registered outputs from the model, clock, compare.
    task automatic step();
        int x;
        int y;
        bit en;
        bit lv;
        bit fv;
        bit hs;
        bit vs;
        logic [23:0] px;
        en = vif.iEnable;
        px = 24'h0;
        lv = 1'b0;
        fv = 1'b0;
        hs = !SP;
        vs = !SP;
        if (!mBusy) begin
            if (en) begin
                mBusy = 1'b1;
                mPos  = 0;
            end
        end else begin
            x = mPos % HT;
            y = mPos / HT;
            if (mPos == 0) begin
                mPat = int'(vif.iPattern);
                mCol = vif.iColor;
            end
            px = refPixel(x, y, mPat, mCol, mFc);
            lv = (x < HA) && (y < VA);
            fv = (y < VA);
            hs = (x >= HA + HFP && x < HA + HFP + HSY) ? SP : !SP;
            vs = (y >= VA + VFP && y < VA + VFP + VSY) ? SP : !SP;
            if (mPos == FRAME - 1 && !mPrevEn && !en) begin
                mBusy = 1'b0;
                mPos  = 0;
            end else begin
                mPos = (mPos + 1) % FRAME;
            end
        end
        if (mPrevFv && !fv) mFc = (mFc + 1) % 65536;
        mPrevFv = fv;
        mPrevEn = en;
        @(posedge iClk);
        #1;
        chk("cycle", obsVec(), 64'({px, hs, vs, lv, fv, 16'(mFc), mBusy}));
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic modelReset();
        mBusy   = 1'b0;
        mPos    = 0;
        mFc     = 0;
        mPrevFv = 1'b0;
        mPrevEn = 1'b0;
    endtask

    initial begin
        int cnt;
        vif.iEnable  = 1'b0;
        vif.iPattern = 3'd0;
        vif.iColor   = 24'h0;

        // Reset levels.
        repeat (2) @(posedge iClk);
        #1;
        chk("reset", obsVec(), 64'({24'h0, !SP, !SP, 2'b00, 16'h0, 1'b0}));
        iRst = 1'b0;
        modelReset();
        steps(2);

        // Solid colour for three frames.
        vif.iPattern = 3'd0;
        vif.iColor   = 24'h123456;
        vif.iEnable  = 1'b1;
        step();
        step();
        chk("solid_px0", 64'({vif.oR, vif.oG, vif.oB, vif.oLineValid}), 64'({24'h123456, 1'b1}));
        steps(3 * FRAME - 1);
        chk("frames3", 64'(vif.oFrameCount), 64'd3);

        // Colour bars on line 0.
        vif.iPattern = 3'd1;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("bar", 64'({vif.oR, vif.oG, vif.oB}), 64'(barColor(i)));
        end
        steps(FRAME - 8);

        // Mid-frame pattern change takes effect next frame.
        vif.iPattern = 3'd0;
        vif.iColor   = 24'($urandom);
        steps(30);
        vif.iPattern = 3'd3;
        steps(FRAME - 30);
        steps(FRAME);

        // Asynchronous reset mid-line.
        steps(5);
        #2;
        iRst = 1'b1;
        #1;
        chk("async_reset", obsVec(), 64'({24'h0, !SP, !SP, 2'b00, 16'h0, 1'b0}));
        @(posedge iClk);
        #1;
        vif.iEnable = 1'b0;
        iRst = 1'b0;
        modelReset();
        steps(2);

        // Stop request at vcnt=1 completes the frame.
        vif.iEnable = 1'b1;
        step();
        steps(HT);
        vif.iEnable = 1'b0;
        cnt = 0;
        while (vif.oBusy && cnt < 200) begin
            step();
            cnt++;
        end
        chk("stop_len", 64'(cnt), 64'(FRAME - HT));
        chk("stop_idle", obsVec(), 64'({24'h0, !SP, !SP, 2'b00, 16'd1, 1'b0}));
        steps(3);

        // Randomized patterns, colours and enable toggles.
        vif.iEnable = 1'b1;
        for (int c = 0; c < 2500; c++) begin
            if ($urandom_range(0, 39) == 0) begin
                vif.iPattern = 3'($urandom_range(0, 7));
                vif.iColor   = 24'($urandom);
            end
            if ($urandom_range(0, 149) == 0) vif.iEnable = ~vif.iEnable;
            step();
        end

        // Black pattern (shows the border when that build option is on).
        vif.iPattern = 3'd5;
        vif.iEnable  = 1'b1;
        steps(2 * FRAME + 20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
